ascii_gen_ctrl: RTL

Sequencer between the MicroBlaze GPIO bank and the ASCII character generator datapath. A rising edge on the GPIO `execute` line starts a run of `target_count` characters. The block requests characters one at a time from the generator and buffers them in a small FIFO. Software pops them through a toggle-acknowledge GPIO protocol and reads `generated_ascii` and `generate_count` back over GPIO.

---
 rtl/ascii_gen_pkg.sv | 23 ++
 rtl/ascii_fifo.sv | 91 +++++++++
 rtl/ascii_gen_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ascii_gen_pkg.sv
// ascii_gen_pkg
//   Shared types and constants for the ASCII generator sequencer.
//   state_t     : controller states
//   ASCII_W     : width of one generated character
//   CNT_W_DEFAULT : default width of the character count (GPIO generate_count)
//   EMPTY_HEAD  : value presented on the FIFO head while the buffer is empty
package ascii_gen_pkg;

  localparam int ASCII_W       = 8;
  localparam int CNT_W_DEFAULT = 12;

  localparam logic [ASCII_W-1:0] EMPTY_HEAD = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    STALL = 3'd3,
    ABORT = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ascii_fifo.sv
// ascii_fifo
//   Synchronous first-word-fall-through FIFO with a registered head.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     push, din    : write request and data
//     pop          : read request (ignored while empty)
//     clear        : flush all entries (takes priority over push/pop)
//     dout         : head entry, EMPTY_HEAD while empty
//     empty, full  : occupancy flags
//     level        : number of stored entries
module ascii_fifo
  import ascii_gen_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ASCII_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;
  logic [AW-1:0] rd_next_addr;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push      = push & ~full;
  assign do_pop       = pop & ~empty;
  assign rd_next_addr = rd_ptr_q[AW-1:0] + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      head_d   = W'(EMPTY_HEAD);
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      // The head register always mirrors the entry at the read pointer.
      // When the last stored entry is popped, a same-cycle push bypasses
      // straight to the head since it is not yet in memory.
      if (do_pop) begin
        if (level == (AW+1)'(1)) head_d = do_push ? din : W'(EMPTY_HEAD);
        else                     head_d = mem_q[rd_next_addr];
      end else if (empty && do_push) begin
        head_d = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= W'(EMPTY_HEAD);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  assign dout = head_q;

  // The controller keeps at most one request outstanding and stalls on full.
  push_while_full_a: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/ascii_gen_ctrl.sv
// ascii_gen_ctrl
//   Sequencer between the GPIO bank and the ASCII character generator.
//   A rising edge on execute starts a run of target_count characters; each
//   character is requested with a one-cycle gen_req pulse and the reply is
//   buffered in a FWFT FIFO that software pops with a toggle acknowledge.
//   Ports:
//     clk, reset_n        : clock, asynchronous active-low reset
//     execute             : run level (rise = start, low = abort/end)
//     target_count        : characters to generate, latched at start
//     gen_req             : one-cycle request pulse to the generator
//     gen_valid, gen_data : generator response strobe and byte
//     rd_ack              : toggle acknowledge, each change pops one entry
//     generated_ascii     : FIFO head byte (00 when empty)
//     char_valid          : FIFO non-empty
//     generate_count      : characters accepted this run
//     busy, done          : run in progress / run completed
module ascii_gen_ctrl
  import ascii_gen_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               execute,
  input  logic [CNT_W-1:0]   target_count,
  output logic               gen_req,
  input  logic               gen_valid,
  input  logic [ASCII_W-1:0] gen_data,
  input  logic               rd_ack,
  output logic [ASCII_W-1:0] generated_ascii,
  output logic               char_valid,
  output logic [CNT_W-1:0]   generate_count,
  output logic               busy,
  output logic               done
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q, state_d;
  logic             execute_q, rd_ack_q;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             gen_req_q, busy_q, done_q;

  logic             exec_rise;
  logic             pop_toggle, pop_eff;
  logic             full_after_push;
  logic             fifo_push, fifo_clear;
  logic             fifo_empty, fifo_full;
  logic [LVL_W-1:0] fifo_level;

  assign exec_rise  = execute & ~execute_q;
  // rd_ack_q follows rd_ack every cycle, so a toggle seen while empty is
  // consumed without popping and is never replayed later.
  assign pop_toggle = rd_ack ^ rd_ack_q;
  assign pop_eff    = pop_toggle & ~fifo_empty;
  // A push makes the FIFO full only if it was one short and nothing leaves.
  assign full_after_push = (fifo_level == LVL_W'(FIFO_DEPTH - 1)) && !pop_eff;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    count_d    = count_q;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (exec_rise) begin
          fifo_clear = 1'b1;
          count_d    = '0;
          target_d   = target_count;
          state_d    = (target_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        state_d = execute ? WAIT : IDLE;
      end
      WAIT: begin
        if (gen_valid) begin
          fifo_push = 1'b1;
          if (count_q != target_q) count_d = count_q + CNT_W'(1);
          if (count_d == target_q)  state_d = DONE;
          else if (!execute)        state_d = IDLE;
          else if (full_after_push) state_d = STALL;
          else                      state_d = ISSUE;
        end else if (!execute) begin
          state_d = ABORT;
        end
      end
      STALL: begin
        if (!execute)       state_d = IDLE;
        else if (!fifo_full) state_d = ISSUE;
      end
      ABORT: begin
        // The reply to the outstanding request is swallowed here.
        if (gen_valid) state_d = IDLE;
      end
      DONE: begin
        if (!execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      execute_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      target_q  <= '0;
      count_q   <= '0;
      gen_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      execute_q <= execute;
      rd_ack_q  <= rd_ack;
      target_q  <= target_d;
      count_q   <= count_d;
      // Outputs are decoded from the next state so they line up with the
      // state register: gen_req is high for exactly the ISSUE cycle.
      gen_req_q <= (state_d == ISSUE);
      busy_q    <= (state_d == ISSUE) || (state_d == WAIT) ||
                   (state_d == STALL) || (state_d == ABORT);
      done_q    <= (state_d == DONE);
    end
  end

  ascii_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ASCII_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (pop_toggle),
    .clear   (fifo_clear),
    .din     (gen_data),
    .dout    (generated_ascii),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign char_valid     = ~fifo_empty;
  assign gen_req        = gen_req_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign generate_count = count_q;

endmodule
